big_core_f2c_rsp_buf: RTL and testbench
=======================================

Name: big_core_f2c_rsp_buf

Overview:
Downstream of the core memory wrapper. It captures the fabric read responses the wrapper emits at Q505H, which carry no backpressure. It holds them in an in-order FIFO and presents them to the tile's outbound fabric arbiter with a valid/ready handshake. It also tracks reads already in flight through the Q503H→Q505H pipe and drives a request-ready credit, so that no response can ever be dropped.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 4 (two entries are covered by in-flight reservation).
INFLIGHT_MAX, 3, saturation bound of the in-flight read counter; must be ≥ the request→response latency (2) + 1.

Ports:
Clk  input  1  core clock
RstN  input  1  asynchronous active-low reset
InReqRdQ503H  input  1  a fabric RD request is accepted by the memory wrapper this cycle (valid && opcode==RD)
ReqReadyQ503H  output  1  upstream may present a RD request this cycle
InRspValidQ505H  input  1  response valid from memory wrapper
InRspQ505H  input  t_tile_trans  response transaction (opcode RD_RSP)
OutRspValid  output  1  head entry valid toward fabric
OutRsp  output  t_tile_trans  head entry
OutRspReady  input  1  fabric consumes head when OutRspValid && OutRspReady
Count  output  $clog2(DEPTH+1)  occupied entries
OverflowErr  output  1  sticky: response arrived with FIFO full

Behaviour:
- Reset (async on RstN low): write ptr, read ptr, Count, in-flight counter and OverflowErr go to 0. OutRspValid=0, OutRsp='0, ReqReadyQ503H=0 while RstN low; ReqReadyQ503H=1 from the first cycle after release. Reset mid-operation discards stored and in-flight responses.
- Storage: DEPTH × t_tile_trans registers; ptrs are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Strict FIFO order.
- Push = InRspValidQ505H && (Count<DEPTH || pop this cycle). Pop = OutRspValid && OutRspReady.
- Push at full with simultaneous pop is accepted; Count is unchanged. Push at full without pop is dropped, and OverflowErr is set until reset.
- Count updates: +1 push-only; -1 pop-only; unchanged for both or neither.
- OutRspValid = (Count != 0), or bypass (see Optional Feature). OutRsp = storage[rd_ptr], registered storage. A pushed entry becomes visible the cycle after push (1-cycle latency).
- InFlight counter (0..INFLIGHT_MAX) tracks reads accepted but not yet returned:
  - +1 on InReqRdQ503H.
  - -1 on InRspValidQ505H.
  - Both in the same cycle → unchanged.
  - Saturates at INFLIGHT_MAX and never goes below 0; a response with InFlight==0 still pushes normally.
- ReqReadyQ503H = (Count + InFlight) < DEPTH (combinational, zero-extended width). This guarantees every accepted read has a reserved slot. A pop in the current cycle is not credited until the next cycle.
- InReqRdQ503H asserted while ReqReadyQ503H=0 is a protocol violation: it is still counted. The resulting overflow is reported via OverflowErr.
- Writes (opcode WR) never enter the block and produce no response.

Optional Feature:
MAFIA_F2C_RSP_BYPASS_EN
- Defined: when Count==0 and InRspValidQ505H, OutRspValid=1 and OutRsp=InRspQ505H in the same cycle (combinational path).
  - If OutRspReady is also 1, the entry is consumed without being written, and Count stays 0.
  - If OutRspReady is 0, the entry is pushed normally.
- Undefined: no combinational path from InRsp* to OutRsp*; minimum input→output latency is 1 cycle.

Test Plan:
- Reset: RstN low for 3 cycles with InRspValidQ505H=1 → OutRspValid=0, Count=0, OverflowErr=0. ReqReadyQ503H=1 in the cycle after release.
- Single read, OutRspReady=1, bypass off: InReqRdQ503H at cycle 0, response data 0xDEADBEEF at cycle 2 → OutRspValid at cycle 3 with data 0xDEADBEEF. Count returns to 0 at cycle 4; InFlight reads 1 in cycles 1–2.
- Credit/fill, OutRspReady=0, DEPTH=4: issue 4 reads back-to-back → ReqReadyQ503H drops to 0 after the 4th accept. The 4 responses (0x1..0x4) are stored, Count=4, OverflowErr stays 0.
- Drain order: from the full state, assert OutRspReady for 4 cycles → outputs 0x1,0x2,0x3,0x4 in order. Count goes 3,2,1,0; ReqReadyQ503H returns to 1 one cycle after the first pop.
- Full with simultaneous push/pop: Count=4, InRspValidQ505H=1 (0x5) and OutRspReady=1 → head popped, 0x5 stored, Count stays 4, no OverflowErr. Repeat with OutRspReady=0 → OverflowErr=1, and the entry is not stored.
- Bypass (MAFIA_F2C_RSP_BYPASS_EN defined): Count=0, response 0xCAFE0001 with OutRspReady=1 → same-cycle OutRspValid=1, OutRsp.data=0xCAFE0001, Count stays 0.

Source files
------------

// File: rtl/big_core_f2c_rsp_buf.sv
// rtl/big_core_f2c_rsp_buf.sv - in-order Q505H read-response buffer with in-flight read credit
// Optional same-cycle response bypass is enabled by defining MAFIA_F2C_RSP_BYPASS_EN.

package big_core_f2c_pkg;
  typedef enum logic [1:0] {
    OP_RD     = 2'd0,
    OP_WR     = 2'd1,
    OP_RD_RSP = 2'd2
  } t_tile_op;

  typedef struct packed {
    t_tile_op    opcode;
    logic [3:0]  src_id;
    logic [31:0] address;
    logic [31:0] data;
  } t_tile_trans;
endpackage

module big_core_f2c_rsp_buf
  import big_core_f2c_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int INFLIGHT_MAX = 3
) (
  input  logic                       Clk,
  input  logic                       RstN,
  input  logic                       InReqRdQ503H,
  output logic                       ReqReadyQ503H,
  input  logic                       InRspValidQ505H,
  input  t_tile_trans                InRspQ505H,
  output logic                       OutRspValid,
  output t_tile_trans                OutRsp,
  input  logic                       OutRspReady,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       OverflowErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(INFLIGHT_MAX + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  t_tile_trans   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_byp_take;
  logic          w_pop;
  logic          w_push;
  logic [SW-1:0] w_credit_sum;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef MAFIA_F2C_RSP_BYPASS_EN
  assign w_bypass = RstN && w_empty && InRspValidQ505H;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response taken by the fabric never touches storage.
  assign w_byp_take = w_bypass && OutRspReady;
  assign w_pop      = !w_empty && OutRspReady;
  assign w_push     = InRspValidQ505H && (!w_full || w_pop) && !w_byp_take;

  assign OutRspValid = !w_empty || w_bypass;
  assign OutRsp      = w_bypass ? InRspQ505H : r_mem[r_rd_ptr];
  assign Count       = r_count;
  assign OverflowErr = r_overflow;

  // Pops only return credit once Count has actually dropped.
  assign w_credit_sum  = SW'(r_count) + SW'(r_inflight);
  assign ReqReadyQ503H = RstN && (w_credit_sum < SW'(DEPTH));

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= InRspQ505H;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (InRspValidQ505H && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_inflight <= '0;
    end else if (InReqRdQ503H && !InRspValidQ505H) begin
      if (r_inflight != IW'(INFLIGHT_MAX)) begin
        r_inflight <= r_inflight + IW'(1);
      end
    end else if (InRspValidQ505H && !InReqRdQ503H) begin
      if (r_inflight != '0) begin
        r_inflight <= r_inflight - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_big_core_f2c_rsp_buf.sv
// tb/tb_big_core_f2c_rsp_buf.sv - directed self-checking bench for big_core_f2c_rsp_buf
// Expectations follow the MAFIA_F2C_RSP_BYPASS_EN setting of the build.

module tb_big_core_f2c_rsp_buf;
  import big_core_f2c_pkg::*;

`ifdef MAFIA_F2C_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk;
  logic        RstN;
  logic        InReqRdQ503H;
  logic        ReqReadyQ503H;
  logic        InRspValidQ505H;
  t_tile_trans InRspQ505H;
  logic        OutRspValid;
  t_tile_trans OutRsp;
  logic        OutRspReady;
  logic [2:0]  Count;
  logic        OverflowErr;

  int n_cmp = 0;
  int n_err = 0;

  big_core_f2c_rsp_buf #(.DEPTH(4), .INFLIGHT_MAX(3)) dut (
    .Clk             (Clk),
    .RstN            (RstN),
    .InReqRdQ503H    (InReqRdQ503H),
    .ReqReadyQ503H   (ReqReadyQ503H),
    .InRspValidQ505H (InRspValidQ505H),
    .InRspQ505H      (InRspQ505H),
    .OutRspValid     (OutRspValid),
    .OutRsp          (OutRsp),
    .OutRspReady     (OutRspReady),
    .Count           (Count),
    .OverflowErr     (OverflowErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic t_tile_trans mk(input logic [31:0] d);
    t_tile_trans t;
    t         = '0;
    t.opcode  = OP_RD_RSP;
    t.address = ~d;
    t.data    = d;
    return t;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    RstN = 1'b0; InRspValidQ505H = 1'b1; InRspQ505H = mk(32'h1234_5678); OutRspReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (OutRspValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b need 0", OutRspValid); end n_cmp++;
      if (Count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d need 0", Count); end n_cmp++;
      if (OverflowErr !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b need 0", OverflowErr); end n_cmp++;
      if (ReqReadyQ503H !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b need 0", ReqReadyQ503H); end n_cmp++;
      if (OutRsp !== t_tile_trans'('0)) begin n_err++; $display("FAIL rst_rsp: got %h need 0", OutRsp); end n_cmp++;
    end
    tick();
    RstN = 1'b1; InRspValidQ505H = 1'b0; OutRspReady = 1'b0;
    @(negedge Clk);
    if (ReqReadyQ503H !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b need 1", ReqReadyQ503H); end n_cmp++;
    if (Count !== 3'd0) begin n_err++; $display("FAIL rel_count: got %0d need 0", Count); end n_cmp++;
  endtask

  task automatic test_single_read();
    tick(); InReqRdQ503H = 1'b1; OutRspReady = 1'b1;
    @(negedge Clk);
    if (ReqReadyQ503H !== 1'b1) begin n_err++; $display("FAIL sr_ready_c0: got %b need 1", ReqReadyQ503H); end n_cmp++;
    tick(); InReqRdQ503H = 1'b0;
    @(negedge Clk);
    if (dut.r_inflight !== 2'd1) begin n_err++; $display("FAIL sr_inflight_c1: got %0d need 1", dut.r_inflight); end n_cmp++;
    if (OutRspValid !== 1'b0) begin n_err++; $display("FAIL sr_valid_c1: got %b need 0", OutRspValid); end n_cmp++;
    tick(); InRspValidQ505H = 1'b1; InRspQ505H = mk(32'hDEAD_BEEF);
    @(negedge Clk);
    if (dut.r_inflight !== 2'd1) begin n_err++; $display("FAIL sr_inflight_c2: got %0d need 1", dut.r_inflight); end n_cmp++;
    if (OutRspValid !== BYP) begin n_err++; $display("FAIL sr_valid_c2: got %b need %b", OutRspValid, BYP); end n_cmp++;
    tick(); InRspValidQ505H = 1'b0; InRspQ505H = mk(32'h0);
    @(negedge Clk);
    if (OutRspValid !== !BYP) begin n_err++; $display("FAIL sr_valid_c3: got %b need %b", OutRspValid, !BYP); end n_cmp++;
    if (OutRsp.data !== (BYP ? 32'h0 : 32'hDEAD_BEEF)) begin n_err++; $display("FAIL sr_data_c3: got %h need %h", OutRsp.data, BYP ? 32'h0 : 32'hDEAD_BEEF); end n_cmp++;
    if (Count !== (BYP ? 3'd0 : 3'd1)) begin n_err++; $display("FAIL sr_count_c3: got %0d need %0d", Count, BYP ? 0 : 1); end n_cmp++;
    tick();
    @(negedge Clk);
    if (Count !== 3'd0) begin n_err++; $display("FAIL sr_count_c4: got %0d need 0", Count); end n_cmp++;
    if (dut.r_inflight !== 2'd0) begin n_err++; $display("FAIL sr_inflight_c4: got %0d need 0", dut.r_inflight); end n_cmp++;
    if (OutRspValid !== 1'b0) begin n_err++; $display("FAIL sr_valid_c4: got %b need 0", OutRspValid); end n_cmp++;
    OutRspReady = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      tick();
      InReqRdQ503H    = (i < 4);
      InRspValidQ505H = (i >= 2);
      InRspQ505H      = mk(32'(i - 1));
      @(negedge Clk);
      if (ReqReadyQ503H !== (i < 4)) begin n_err++; $display("FAIL fill_ready_%0d: got %b need %b", i, ReqReadyQ503H, i < 4); end n_cmp++;
      if (OutRspValid !== (i >= (BYP ? 2 : 3))) begin n_err++; $display("FAIL fill_valid_%0d: got %b need %b", i, OutRspValid, i >= (BYP ? 2 : 3)); end n_cmp++;
    end
    tick(); InReqRdQ503H = 1'b0; InRspValidQ505H = 1'b0;
    @(negedge Clk);
    if (Count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d need 4", Count); end n_cmp++;
    if (OverflowErr !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b need 0", OverflowErr); end n_cmp++;
    if (ReqReadyQ503H !== 1'b0) begin n_err++; $display("FAIL fill_ready_full: got %b need 0", ReqReadyQ503H); end n_cmp++;
    if (OutRsp.data !== 32'h1) begin n_err++; $display("FAIL fill_head: got %h need 1", OutRsp.data); end n_cmp++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      tick(); OutRspReady = 1'b1;
      @(negedge Clk);
      if (OutRsp.data !== 32'(i + 1)) begin n_err++; $display("FAIL drain_data_%0d: got %h need %h", i, OutRsp.data, i + 1); end n_cmp++;
      if (Count !== 3'(4 - i)) begin n_err++; $display("FAIL drain_count_%0d: got %0d need %0d", i, Count, 4 - i); end n_cmp++;
      if (ReqReadyQ503H !== (i >= 1)) begin n_err++; $display("FAIL drain_ready_%0d: got %b need %b", i, ReqReadyQ503H, i >= 1); end n_cmp++;
    end
    tick(); OutRspReady = 1'b0;
    @(negedge Clk);
    if (Count !== 3'd0) begin n_err++; $display("FAIL drain_count_end: got %0d need 0", Count); end n_cmp++;
    if (OutRspValid !== 1'b0) begin n_err++; $display("FAIL drain_valid_end: got %b need 0", OutRspValid); end n_cmp++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q = '{32'h12, 32'h13, 32'h14, 32'h5};
    for (int i = 0; i < 4; i++) begin
      tick(); InRspValidQ505H = 1'b1; InRspQ505H = mk(32'h11 + 32'(i)); OutRspReady = 1'b0;
    end
    tick(); InRspValidQ505H = 1'b1; InRspQ505H = mk(32'h5); OutRspReady = 1'b1;
    @(negedge Clk);
    if (Count !== 3'd4) begin n_err++; $display("FAIL fpp_count_pre: got %0d need 4", Count); end n_cmp++;
    if (OutRsp.data !== 32'h11) begin n_err++; $display("FAIL fpp_head: got %h need 11", OutRsp.data); end n_cmp++;
    if (ReqReadyQ503H !== 1'b0) begin n_err++; $display("FAIL fpp_ready: got %b need 0", ReqReadyQ503H); end n_cmp++;
    tick(); InRspQ505H = mk(32'h6); OutRspReady = 1'b0;
    @(negedge Clk);
    if (Count !== 3'd4) begin n_err++; $display("FAIL fpp_count_pp: got %0d need 4", Count); end n_cmp++;
    if (OverflowErr !== 1'b0) begin n_err++; $display("FAIL fpp_ovf_pp: got %b need 0", OverflowErr); end n_cmp++;
    tick(); InRspValidQ505H = 1'b0;
    @(negedge Clk);
    if (OverflowErr !== 1'b1) begin n_err++; $display("FAIL fpp_ovf_set: got %b need 1", OverflowErr); end n_cmp++;
    if (Count !== 3'd4) begin n_err++; $display("FAIL fpp_count_ovf: got %0d need 4", Count); end n_cmp++;
    for (int i = 0; i < 4; i++) begin
      tick(); OutRspReady = 1'b1;
      @(negedge Clk);
      if (OutRsp.data !== exp_q[i]) begin n_err++; $display("FAIL fpp_drain_%0d: got %h need %h", i, OutRsp.data, exp_q[i]); end n_cmp++;
    end
    tick(); OutRspReady = 1'b0;
    @(negedge Clk);
    if (Count !== 3'd0) begin n_err++; $display("FAIL fpp_count_end: got %0d need 0", Count); end n_cmp++;
    if (OverflowErr !== 1'b1) begin n_err++; $display("FAIL fpp_ovf_sticky: got %b need 1", OverflowErr); end n_cmp++;
  endtask

  task automatic test_bypass();
    tick(); InRspValidQ505H = 1'b1; InRspQ505H = mk(32'hCAFE_0001); OutRspReady = 1'b1;
    @(negedge Clk);
    if (OutRspValid !== BYP) begin n_err++; $display("FAIL byp_valid_same: got %b need %b", OutRspValid, BYP); end n_cmp++;
`ifdef MAFIA_F2C_RSP_BYPASS_EN
    if (OutRsp.data !== 32'hCAFE_0001) begin n_err++; $display("FAIL byp_data_same: got %h need cafe0001", OutRsp.data); end n_cmp++;
`endif
    tick(); InRspValidQ505H = 1'b0;
    @(negedge Clk);
    if (Count !== (BYP ? 3'd0 : 3'd1)) begin n_err++; $display("FAIL byp_count: got %0d need %0d", Count, BYP ? 0 : 1); end n_cmp++;
    if (OutRspValid !== !BYP) begin n_err++; $display("FAIL byp_valid_next: got %b need %b", OutRspValid, !BYP); end n_cmp++;
`ifndef MAFIA_F2C_RSP_BYPASS_EN
    if (OutRsp.data !== 32'hCAFE_0001) begin n_err++; $display("FAIL byp_data_next: got %h need cafe0001", OutRsp.data); end n_cmp++;
`endif
    tick(); OutRspReady = 1'b0;
    @(negedge Clk);
    if (Count !== 3'd0) begin n_err++; $display("FAIL byp_count_end: got %0d need 0", Count); end n_cmp++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); InRspValidQ505H = (i < 2); InReqRdQ503H = (i >= 2); InRspQ505H = mk(32'h70 + 32'(i));
    end
    tick(); InRspValidQ505H = 1'b0; InReqRdQ503H = 1'b0;
    @(negedge Clk);
    if (ReqReadyQ503H !== 1'b0) begin n_err++; $display("FAIL mr_ready_pre: got %b need 0", ReqReadyQ503H); end n_cmp++;
    if (Count !== 3'd2) begin n_err++; $display("FAIL mr_count_pre: got %0d need 2", Count); end n_cmp++;
    tick(); RstN = 1'b0;
    #1;
    if (Count !== 3'd0) begin n_err++; $display("FAIL mr_count_async: got %0d need 0", Count); end n_cmp++;
    if (OverflowErr !== 1'b0) begin n_err++; $display("FAIL mr_ovf_async: got %b need 0", OverflowErr); end n_cmp++;
    if (OutRspValid !== 1'b0) begin n_err++; $display("FAIL mr_valid_async: got %b need 0", OutRspValid); end n_cmp++;
    tick(); RstN = 1'b1;
    @(negedge Clk);
    if (ReqReadyQ503H !== 1'b1) begin n_err++; $display("FAIL mr_ready_post: got %b need 1", ReqReadyQ503H); end n_cmp++;
    if (dut.r_inflight !== 2'd0) begin n_err++; $display("FAIL mr_inflight_post: got %0d need 0", dut.r_inflight); end n_cmp++;
  endtask

  initial begin
    RstN = 1'b0; InReqRdQ503H = 1'b0; InRspValidQ505H = 1'b0; InRspQ505H = '0; OutRspReady = 1'b0;
    test_reset();
    test_single_read();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_bypass();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
